// File: rtl/pwm_cfg_pkg.sv
// pwm_cfg_pkg: shared constants and types for the SPI configuration port
// of the PWM stage.
//   - register addresses carried in cmd[1:0]
//   - ID register contents, frame geometry, reset values of the PWM settings
//   - SPI frame FSM state type
package pwm_cfg_pkg;

    localparam logic [1:0] ADDR_ID   = 2'd0;
    localparam logic [1:0] ADDR_DUTY = 2'd1;
    localparam logic [1:0] ADDR_MAX  = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    localparam logic [7:0] ID_VALUE = 8'hA5;

    localparam int unsigned CMD_BITS   = 8;
    localparam int unsigned FRAME_BITS = 16;

    localparam logic [7:0] RST_DUTY = 8'h00;
    localparam logic [7:0] RST_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: brings one asynchronous SPI line into the clk domain and
// flags its edges.
//   clk   in  system clock
//   rst   in  asynchronous active-high reset
//   din   in  asynchronous input line
//   rise  out 1-cycle pulse on a synchronized 0->1 transition
//   fall  out 1-cycle pulse on a synchronized 1->0 transition
// RST_VAL is the idle level of the line so reset release never fakes an edge.
module spi_sync_edge
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] stages;
    logic                   level;
    logic                   prev;

    assign level = stages[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stages <= {SYNC_STAGES{RST_VAL}};
            prev   <= RST_VAL;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], din};
            prev   <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/pwm_spi_config.sv
// pwm_spi_config: SPI mode-0 slave holding the PWM settings.
//   clk        in  system clock (only clock domain)
//   rst        in  asynchronous active-high reset
//   spi_sclk   in  SPI clock from host (async, <= clk/8)
//   spi_mosi   in  SPI data in (async)
//   spi_cs_n   in  SPI chip select, active low (async)
//   spi_miso   out SPI data out, MSB first
//   period_end in  1-cycle pulse from the PWM counter wrap
//   duty       out active duty value
//   max_value  out active period max
//   pwm_en     out PWM enable
//   frame_err  out sticky flag: frame cut short by cs_n
//   wr_strobe  out 1-cycle pulse per completed write frame
// Frame: cmd byte {wr, 5'bx, addr[1:0]} then data byte. DUTY/MAX writes land
// in shadows and reach the outputs on a period boundary (or at once while
// the PWM is disabled).
module pwm_spi_config
    import pwm_cfg_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    input  logic             spi_cs_n,
    output logic             spi_miso,
    input  logic             period_end,
    output logic [WIDTH-1:0] duty,
    output logic [WIDTH-1:0] max_value,
    output logic             pwm_en,
    output logic             frame_err,
    output logic             wr_strobe
);

    localparam logic [3:0] CMD_LAST   = 4'(CMD_BITS - 1);
    localparam logic [3:0] LOAD_BIT   = 4'(CMD_BITS);
    localparam logic [3:0] FRAME_LAST = 4'(FRAME_BITS - 1);

    logic sclk_rise, sclk_fall;
    logic cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_pipe;
    logic mosi_s;

    state_t           state;
    logic [3:0]       bit_cnt;
    logic [WIDTH-2:0] rx_shift;
    logic [WIDTH-1:0] tx_shift;
    logic             cmd_write;
    logic [1:0]       cmd_addr;

    logic [WIDTH-1:0] duty_sh;
    logic [WIDTH-1:0] max_sh;
    logic             pending;

    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] readback;
    logic             frame_last;
    logic             wr_en;
    logic             frame_abort;
    logic             commit;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // cs_n idles high, so its synchronizer resets high.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (spi_cs_n),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    // Same depth as the sclk path, so mosi is aligned with the rise pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mosi_pipe <= '0;
        end else begin
            mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign mosi_s = mosi_pipe[SYNC_STAGES-1];

    assign wr_data     = {rx_shift, mosi_s};
    assign frame_last  = (state == DATA) && sclk_rise && (bit_cnt == FRAME_LAST);
    assign wr_en       = frame_last && cmd_write;
    assign frame_abort = ((state == CMD) || (state == DATA)) && cs_rise;
    assign commit      = pending && (period_end || !pwm_en);
    assign spi_miso    = tx_shift[WIDTH-1];

    always_comb begin
        readback = '0;
        case (cmd_addr)
            ADDR_ID:   readback = WIDTH'(ID_VALUE);
            ADDR_DUTY: readback = duty_sh;
            ADDR_MAX:  readback = max_sh;
            ADDR_CTRL: readback = WIDTH'({5'b0, pending, frame_err, pwm_en});
            default:   readback = '0;
        endcase
    end

    // Frame sequencing, receive and transmit shifters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            cmd_write <= 1'b0;
            cmd_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state    <= CMD;
                        bit_cnt  <= '0;
                        tx_shift <= '0;
                    end
                end
                CMD: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        tx_shift <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[WIDTH-3:0], mosi_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == CMD_LAST) begin
                                cmd_write <= rx_shift[6];
                                cmd_addr  <= {rx_shift[0], mosi_s};
                                state     <= DATA;
                            end
                        end
                        if (sclk_fall) begin
                            tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        tx_shift <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= {rx_shift[WIDTH-3:0], mosi_s};
                            bit_cnt  <= bit_cnt + 4'd1;
                            if (bit_cnt == FRAME_LAST) begin
                                state <= DONE;
                            end
                        end
                        if (sclk_fall) begin
                            // First fall after the command byte: present the
                            // readback MSB ahead of the 9th rise.
                            if (bit_cnt == LOAD_BIT) begin
                                tx_shift <= cmd_write ? '0 : readback;
                            end else begin
                                tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                DONE: begin
                    if (cs_rise) begin
                        state    <= IDLE;
                        tx_shift <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register file, shadow commit and status. The commit reads the shadows
    // before this cycle's write lands, so a write coinciding with period_end
    // waits for the next boundary (pending is re-set by the write).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_sh   <= WIDTH'(RST_DUTY);
            max_sh    <= WIDTH'(RST_MAX);
            duty      <= WIDTH'(RST_DUTY);
            max_value <= WIDTH'(RST_MAX);
            pending   <= 1'b0;
            pwm_en    <= 1'b0;
            frame_err <= 1'b0;
            wr_strobe <= 1'b0;
        end else begin
            wr_strobe <= wr_en;
            if (commit) begin
                duty      <= duty_sh;
                max_value <= max_sh;
                pending   <= 1'b0;
            end
            if (frame_abort) begin
                frame_err <= 1'b1;
            end
            if (wr_en) begin
                case (cmd_addr)
                    ADDR_DUTY: begin
                        duty_sh <= wr_data;
                        pending <= 1'b1;
                    end
                    ADDR_MAX: begin
                        max_sh  <= wr_data;
                        pending <= 1'b1;
                    end
                    ADDR_CTRL: begin
                        pwm_en <= wr_data[0];
                        if (wr_data[1]) begin
                            frame_err <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_spi_config.sv
// tb_pwm_spi_config: drives SPI frames and period_end pulses into
// pwm_spi_config and checks every output each cycle against a
// transaction-level model of the register file.
module tb_pwm_spi_config;

    localparam int HALF = 4;      // sclk half period in clk cycles (clk/8)
    localparam int SS   = 2;
    localparam int LAT  = SS + 1; // input edge to register update, in clk cycles

    localparam int EV_DONE  = 0;
    localparam int EV_ABORT = 1;
    localparam int EV_LOAD  = 2;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [15:0] word;
    } ev_t;

    logic       clk, rst;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_miso;
    logic       period_end;
    logic [7:0] duty, max_value;
    logic       pwm_en, frame_err, wr_strobe;

    int errors = 0;
    int checks = 0;
    int strobe_cnt = 0;
    bit chk_on = 0;
    bit pe_rand = 0;

    // Model state
    ev_t         evq[$];
    int unsigned mcyc = 0;
    logic [7:0]  m_duty, m_max, m_sh_duty, m_sh_max, m_rb;
    logic        m_en, m_err, m_pend, m_strobe;

    pwm_spi_config #(.WIDTH(8), .SYNC_STAGES(SS)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_cs_n   (spi_cs_n),
        .spi_miso   (spi_miso),
        .period_end (period_end),
        .duty       (duty),
        .max_value  (max_value),
        .pwm_en     (pwm_en),
        .frame_err  (frame_err),
        .wr_strobe  (wr_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: settings change only at transaction boundaries, from the rules
    // for writes, aborts, and shadow commits.
    always @(posedge clk or posedge rst) begin : model
        logic [7:0] n_duty, n_max, n_sh_duty, n_sh_max;
        logic       n_en, n_err, n_pend, n_strobe;
        ev_t        e;
        if (rst) begin
            m_duty = 8'h00; m_max = 8'hFF; m_sh_duty = 8'h00; m_sh_max = 8'hFF;
            m_en = 1'b0; m_err = 1'b0; m_pend = 1'b0; m_strobe = 1'b0;
            evq.delete();
        end else begin
            mcyc++;
            n_duty = m_duty; n_max = m_max; n_sh_duty = m_sh_duty; n_sh_max = m_sh_max;
            n_en = m_en; n_err = m_err; n_pend = m_pend; n_strobe = 1'b0;
            if (m_pend && (period_end || !m_en)) begin
                n_duty = m_sh_duty;
                n_max  = m_sh_max;
                n_pend = 1'b0;
            end
            while (evq.size() > 0 && evq[0].cyc <= mcyc) begin
                e = evq.pop_front();
                case (e.kind)
                    EV_LOAD: begin
                        case (e.word[9:8])
                            2'd0:    m_rb = 8'hA5;
                            2'd1:    m_rb = m_sh_duty;
                            2'd2:    m_rb = m_sh_max;
                            default: m_rb = {5'b0, m_pend, m_err, m_en};
                        endcase
                    end
                    EV_ABORT: n_err = 1'b1;
                    default: begin
                        if (e.word[15]) begin
                            n_strobe = 1'b1;
                            case (e.word[9:8])
                                2'd1: begin n_sh_duty = e.word[7:0]; n_pend = 1'b1; end
                                2'd2: begin n_sh_max  = e.word[7:0]; n_pend = 1'b1; end
                                2'd3: begin
                                    n_en = e.word[0];
                                    if (e.word[1]) n_err = 1'b0;
                                end
                                default: ;
                            endcase
                        end
                    end
                endcase
            end
            m_duty = n_duty; m_max = n_max; m_sh_duty = n_sh_duty; m_sh_max = n_sh_max;
            m_en = n_en; m_err = n_err; m_pend = n_pend; m_strobe = n_strobe;
        end
    end

    always @(negedge clk) begin
        if (chk_on && !rst) begin
            check("duty", duty, m_duty);
            check("max_value", max_value, m_max);
            check("pwm_en", pwm_en, m_en);
            check("frame_err", frame_err, m_err);
            check("wr_strobe", wr_strobe, m_strobe);
            if (wr_strobe === 1'b1) strobe_cnt++;
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        if (pe_rand) period_end = !period_end && ($urandom_range(0, 11) == 0);
        else         period_end = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic push_ev(input int kind, input logic [15:0] word);
        ev_t e;
        e.cyc  = mcyc + LAT;
        e.kind = kind;
        e.word = word;
        evq.push_back(e);
    endtask

    task automatic send_bits(input logic [15:0] word, input int nbits, input bit pe_at_end,
                             output logic [7:0] rd);
        rd = '0;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = word[15-i];
            wait_cycles(HALF);
            if (i >= 8) rd = {rd[6:0], spi_miso};
            spi_sclk = 1'b1;
            if (i == 15) push_ev(EV_DONE, word);
            if (i == 15 && pe_at_end) begin
                wait_cycles(2);
                period_end = 1'b1;   // lands on the same clk edge as the write
                wait_cycles(HALF - 2);
            end else begin
                wait_cycles(HALF);
            end
            spi_sclk = 1'b0;
            if (i == 7) push_ev(EV_LOAD, word);
        end
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [7:0] data, input int nbits,
                             input bit pe_at_end, output logic [7:0] rd);
        tick();
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        send_bits({cmd, data}, nbits, pe_at_end, rd);
        wait_cycles(HALF);
        spi_cs_n = 1'b1;
        if (nbits < 16) push_ev(EV_ABORT, {cmd, data});
        wait_cycles(LAT + 3);
        if (nbits == 16 && !cmd[7]) check("readback", rd, m_rb);
    endtask

    task automatic pulse_pe();
        tick();
        period_end = 1'b1;
        tick();
    endtask

    initial begin : stim
        logic [7:0] rd, c, d;
        int         s0, nb;

        rst = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1; period_end = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        chk_on = 1'b1;
        tick();
        check("rst duty", duty, 8'h00);
        check("rst max_value", max_value, 8'hFF);
        check("rst pwm_en", pwm_en, 1'b0);
        check("rst frame_err", frame_err, 1'b0);
        check("rst miso", spi_miso, 1'b0);
        check("rst wr_strobe", wr_strobe, 1'b0);

        spi_frame(8'h00, 8'h00, 16, 1'b0, rd);
        check("id read", rd, 8'hA5);

        s0 = strobe_cnt;
        spi_frame(8'h81, 8'h40, 16, 1'b0, rd);
        check("duty direct", duty, 8'h40);
        check("strobe count", strobe_cnt - s0, 1);

        spi_frame(8'h83, 8'h01, 16, 1'b0, rd);
        check("enable", pwm_en, 1'b1);
        spi_frame(8'h82, 8'h7F, 16, 1'b0, rd);
        check("max held", max_value, 8'hFF);
        spi_frame(8'h03, 8'h00, 16, 1'b0, rd);
        check("ctrl pending", rd, 8'h05);
        spi_frame(8'h01, 8'h00, 16, 1'b0, rd);
        check("duty shadow read", rd, 8'h40);
        check("max still held", max_value, 8'hFF);
        pulse_pe();
        tick();
        check("max committed", max_value, 8'h7F);

        spi_frame(8'h81, 8'h11, 16, 1'b0, rd);
        spi_frame(8'h81, 8'h22, 16, 1'b1, rd);
        check("coincide old", duty, 8'h11);
        pulse_pe();
        tick();
        check("coincide new", duty, 8'h22);

        spi_frame(8'h81, 8'h99, 11, 1'b0, rd);
        check("abort duty", duty, 8'h22);
        check("abort err", frame_err, 1'b1);
        spi_frame(8'h83, 8'h02, 16, 1'b0, rd);
        check("err cleared", frame_err, 1'b0);
        check("en cleared", pwm_en, 1'b0);

        tick();
        spi_cs_n = 1'b0;
        wait_cycles(HALF);
        send_bits(16'h8133, 10, 1'b0, rd);
        tick();
        rst = 1'b1;
        #1;
        check("midrst duty", duty, 8'h00);
        check("midrst max", max_value, 8'hFF);
        check("midrst en", pwm_en, 1'b0);
        check("midrst err", frame_err, 1'b0);
        check("midrst miso", spi_miso, 1'b0);
        check("midrst strobe", wr_strobe, 1'b0);
        spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(4);
        spi_frame(8'h00, 8'h00, 16, 1'b0, rd);
        check("post rst id", rd, 8'hA5);
        spi_frame(8'h81, 8'h5A, 16, 1'b0, rd);
        check("post rst duty", duty, 8'h5A);

        pe_rand = 1'b1;
        for (int n = 0; n < 80; n++) begin
            c = 8'($urandom);
            d = 8'($urandom);
            nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 15) : 16;
            spi_frame(c, d, nb, 1'b0, rd);
        end
        pe_rand = 1'b0;
        wait_cycles(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
